squeeze: RTL

Output stage of the SHA3-512 core, at the opposite end of the sponge from the absorb stage. It takes the 576-bit rate output and the `ready` indication from the Keccak-f permutation. It captures the 512-bit digest and serializes it as sixteen 32-bit words over a valid/ready stream toward the Caravel wishbone/logic-analyzer glue. It also flags permutation results that arrive while a digest is still being drained.

---
 rtl/sha3_pkg.sv | 16 +
 rtl/squeeze_ser.sv | 47 ++++
 rtl/squeeze.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/sha3_pkg.sv
// Shared SHA3-512 constants and the squeeze FSM state type.
package sha3_pkg;

  localparam int RATE_W   = 576;
  localparam int CAP_W    = 1024;
  localparam int DIGEST_W = 512;
  localparam int WORD_W   = 32;
  localparam int NWORDS   = DIGEST_W / WORD_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } squeeze_state_t;

endpackage

// File: rtl/squeeze_ser.sv
// Loadable right-shift register for the digest, with the word counter and
// the final-word indication. The counter saturates at NWORDS-1.
module squeeze_ser #(
  parameter int DIGEST_W = 512,
  parameter int WORD_W   = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [DIGEST_W-1:0] load_data,
  input  logic                shift,
  output logic [WORD_W-1:0]   word,
  output logic                last
);

  localparam int NWORDS = DIGEST_W / WORD_W;
  localparam int CNT_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NWORDS - 1);

  logic [DIGEST_W-1:0] shreg_r;
  logic [CNT_W-1:0]    cnt_r;

  // Capture the digest on load, otherwise shift one word out per transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_r <= '0;
      cnt_r   <= '0;
    end else if (load) begin
      shreg_r <= load_data;
      cnt_r   <= '0;
    end else if (shift) begin
      shreg_r <= shreg_r >> WORD_W;
      if (cnt_r != LAST_IDX) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end else begin
        cnt_r <= cnt_r;
      end
    end else begin
      shreg_r <= shreg_r;
      cnt_r   <= cnt_r;
    end
  end

  assign word = shreg_r[WORD_W-1:0];
  assign last = (cnt_r == LAST_IDX);

endmodule

// File: rtl/squeeze.sv
// SHA3-512 squeeze stage: captures the digest from the Keccak-f rate output
// on a rising abs_ready_i and streams it out as WORD_W-bit words.
// Optional macro SQUEEZE_BYTE_SWAP_EN byte-reverses each output word.
module squeeze #(
  parameter int RATE_W   = sha3_pkg::RATE_W,
  parameter int DIGEST_W = sha3_pkg::DIGEST_W,
  parameter int WORD_W   = sha3_pkg::WORD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [RATE_W-1:0] abs_data_i,
  input  logic              abs_ready_i,
  output logic [WORD_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              dout_last,
  output logic              busy,
  output logic              digest_done,
  output logic              overrun
);

  import sha3_pkg::squeeze_state_t;
  import sha3_pkg::IDLE;
  import sha3_pkg::STREAM;
  import sha3_pkg::DONE;

  squeeze_state_t state_r, state_n;
  logic           abs_ready_q;
  logic           rise;
  logic           load;
  logic           shift;
  logic           ovr_set;
  logic           overrun_r;
  logic [WORD_W-1:0] ser_word;
  logic           ser_last;

  // Reverse byte order within a word for big-endian host reading.
  function automatic logic [WORD_W-1:0] swap_bytes(input logic [WORD_W-1:0] w);
    logic [WORD_W-1:0] r;
    r = '0;
    for (int i = 0; i < WORD_W / 8; i++) begin
      r[8*i +: 8] = w[WORD_W-8-8*i +: 8];
    end
    return r;
  endfunction

  // Upper rate bits beyond the digest carry no output information.
  if (RATE_W > DIGEST_W) begin : g_unused
    logic unused_rate_bits;
    assign unused_rate_bits = ^abs_data_i[RATE_W-1:DIGEST_W];
  end

  assign rise = abs_ready_i & ~abs_ready_q;

  // State register and the delayed copy of abs_ready_i for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      abs_ready_q <= 1'b0;
    end else begin
      state_r     <= state_n;
      abs_ready_q <= abs_ready_i;
    end
  end

  // Next-state logic; a rise outside IDLE is dropped and flagged.
  always_comb begin
    state_n = state_r;
    load    = 1'b0;
    shift   = 1'b0;
    ovr_set = 1'b0;
    case (state_r)
      IDLE: begin
        if (rise) begin
          load    = 1'b1;
          state_n = STREAM;
        end else begin
          state_n = IDLE;
        end
      end
      STREAM: begin
        ovr_set = rise;
        if (dout_ready) begin
          shift = 1'b1;
          if (ser_last) begin
            state_n = DONE;
          end else begin
            state_n = STREAM;
          end
        end else begin
          state_n = STREAM;
        end
      end
      DONE: begin
        ovr_set = rise;
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Sticky overrun flag, cleared only by an accepted capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun_r <= 1'b0;
    end else if (load) begin
      overrun_r <= 1'b0;
    end else if (ovr_set) begin
      overrun_r <= 1'b1;
    end else begin
      overrun_r <= overrun_r;
    end
  end

  squeeze_ser #(
    .DIGEST_W (DIGEST_W),
    .WORD_W   (WORD_W)
  ) u_ser (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_data (abs_data_i[DIGEST_W-1:0]),
    .shift     (shift),
    .word      (ser_word),
    .last      (ser_last)
  );

`ifdef SQUEEZE_BYTE_SWAP_EN
  assign dout = swap_bytes(ser_word);
`else
  assign dout = ser_word;
`endif

  assign dout_valid  = (state_r == STREAM);
  assign dout_last   = (state_r == STREAM) & ser_last;
  assign busy        = (state_r != IDLE);
  assign digest_done = (state_r == DONE);
  assign overrun     = overrun_r;

endmodule
